// File: rtl/add_seq.sv
// Multi-cycle adder/subtractor: sums CHUNK bits per clock with a registered ripple carry,
// valid/ready handshakes on both sides, and carry-out / signed-overflow flags.
module add_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [IW-1:0]    idx_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] out_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] sum_chunk;
  logic             carry_next;
  logic             msb_carry_in;

  always_comb begin
    a_chunk = a_reg[idx_reg*CHUNK +: CHUNK];
    b_chunk = b_reg[idx_reg*CHUNK +: CHUNK];
    {carry_next, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_reg);
    // Carry into the top bit recovered from its sum bit; works for any CHUNK including 1.
    msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum_chunk[CHUNK-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      out_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= num1;
            b_reg     <= sub ? ~num2 : num2;
            carry_reg <= sub ? 1'b1 : cin;
            idx_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          out_reg[idx_reg*CHUNK +: CHUNK] <= sum_chunk;
          carry_reg <= carry_next;
          if (idx_reg == LAST) begin
            cout_reg  <= carry_next;
            ovf_reg   <= msb_carry_in ^ carry_next;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == DONE);
  assign out       = out_reg;
  assign cout      = cout_reg;
  assign overflow  = ovf_reg;

endmodule
